// File: rtl/board_io_defs.sv
// Shared board-I/O definitions: read-port address map, button-word layout and
// the default debounce interval used by the board input blocks.
package board_io_defs;

  localparam logic KEY_ADDR_SW  = 1'b0;
  localparam logic KEY_ADDR_BTN = 1'b1;

  localparam int KEY_PEND_LSB = 16;

  localparam int KEY_DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // Button word: pending flags in the upper half, debounced levels in the lower half.
  function automatic logic [31:0] key_btn_word(input logic [15:0] pend, input logic [15:0] lvl);
    return (32'(pend) << KEY_PEND_LSB) | 32'(lvl);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input bit: 2-flop synchroniser, stability counter and debounced level,
// plus a combinational pulse flagging the edge on which the level rises.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [CW-1:0] cnt;

  assign sync = sync_q[1];

  // High on the edge where stable is about to go 0->1.
  assign rise = sync && !stable && (cnt == CNT_LAST);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_key_reader.sv
// Board switch/button reader: debounced levels, sticky clear-on-read button
// pending bits and a registered CPU read port. Optional irq with KEY_IRQ_EN.
module board_key_reader
  import board_io_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT,
  parameter int N_SW            = 16,
  parameter int N_BTN           = 5
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             rd_en,
  input  logic             rd_addr,
`ifdef KEY_IRQ_EN
  output logic             irq,
`endif
  output logic [31:0]      rd_data,
  output logic             rd_valid
);

  logic [N_SW-1:0]  sw_stable;
  logic [N_SW-1:0]  sw_rise_unused;
  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] pending;
  logic [31:0]      rd_word;
  logic             clear_rd;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk_in (clk_in),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .stable (sw_stable[i]),
      .rise   (sw_rise_unused[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk_in (clk_in),
      .reset  (reset),
      .raw    (btn_raw[i]),
      .stable (btn_stable[i]),
      .rise   (btn_rise[i])
    );
  end

  // NOTE: rd_word gets a default before the branch so no latch is inferred.
  always_comb begin
    rd_word = 32'(sw_stable);
    if (rd_addr == KEY_ADDR_BTN) begin
      rd_word = key_btn_word(16'(pending), 16'(btn_stable));
    end
  end

  assign clear_rd = rd_en && (rd_addr == KEY_ADDR_BTN);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word;
      end
      // A rise on the reading edge survives the clear; the CPU sees it next time.
      if (clear_rd) begin
        pending <= btn_rise;
      end else begin
        pending <= pending | btn_rise;
      end
    end
  end

`ifdef KEY_IRQ_EN
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |pending;
    end
  end
`endif

endmodule

// File: tb/tb_board_key_reader.sv
// Directed self-checking bench for board_key_reader with a 4-cycle debounce.
module tb_board_key_reader;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] sw_raw = '0;
  logic [4:0]  btn_raw = '0;
  logic        rd_en = 1'b0;
  logic        rd_addr = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
`ifdef KEY_IRQ_EN
  logic        irq;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  board_key_reader #(
    .DEBOUNCE_CYCLES (4),
    .N_SW            (16),
    .N_BTN           (5)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .btn_raw  (btn_raw),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
`ifdef KEY_IRQ_EN
    .irq      (irq),
`endif
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  typedef struct {
    logic [15:0] sw;
    logic [31:0] exp_before;
    logic [31:0] exp_after;
  } sw_vec_t;

  sw_vec_t sw_tab[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_read(input logic addr, output logic [31:0] data);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick();
    data  = rd_data;
    rd_en = 1'b0;
    check("rd_valid_pulse", 32'(rd_valid), 32'd1);
  endtask

  logic [31:0] d;

  initial begin
    sw_tab[0] = '{16'hA5A5, 32'h0000_0000, 32'h0000_A5A5};
    sw_tab[1] = '{16'hFFFF, 32'h0000_A5A5, 32'h0000_FFFF};
    sw_tab[2] = '{16'h8001, 32'h0000_FFFF, 32'h0000_8001};
    sw_tab[3] = '{16'h0000, 32'h0000_8001, 32'h0000_0000};

    // Reset held with noisy pins and a read strobe active.
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw_raw  = 16'($urandom);
      btn_raw = 5'($urandom);
      rd_en   = 1'b1;
      rd_addr = 1'($urandom);
      tick();
    end
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", rd_data, 32'h0);
`ifdef KEY_IRQ_EN
    check("reset_irq", 32'(irq), 32'd0);
`endif
    rd_en   = 1'b0;
    sw_raw  = '0;
    btn_raw = '0;
    tick();
    reset = 1'b1;
    tick(2);
    do_read(1'b0, d);
    check("post_reset_sw", d, 32'h0);
    do_read(1'b1, d);
    check("post_reset_btn", d, 32'h0);
    tick();
    check("rd_valid_idle", 32'(rd_valid), 32'd0);
    check("rd_data_hold", rd_data, 32'h0);

    // Switch debounce: the read on the 6th edge still sees the old level.
    for (int i = 0; i < 4; i++) begin
      sw_raw = sw_tab[i].sw;
      tick(5);
      do_read(1'b0, d);
      check($sformatf("sw_before_%0d", i), d, sw_tab[i].exp_before);
      do_read(1'b0, d);
      check($sformatf("sw_after_%0d", i), d, sw_tab[i].exp_after);
    end

    // Glitch of 3 cycles on btn[2] never reaches the stable level.
    btn_raw[2] = 1'b1;
    tick(3);
    btn_raw[2] = 1'b0;
    tick(8);
    do_read(1'b1, d);
    check("glitch_btn", d, 32'h0);
`ifdef KEY_IRQ_EN
    check("glitch_irq", 32'(irq), 32'd0);
`endif

    // Press and hold btn[0], then clear-on-read, then release.
    btn_raw[0] = 1'b1;
    tick(7);
    do_read(1'b1, d);
    check("press_first_read", d, 32'h0001_0001);
    do_read(1'b1, d);
    check("press_second_read", d, 32'h0000_0001);
    btn_raw[0] = 1'b0;
    tick(7);
    do_read(1'b1, d);
    check("release_read", d, 32'h0);

    // btn[1] stable rise lands on the same edge as a button read.
    btn_raw[1] = 1'b1;
    tick(5);
    do_read(1'b1, d);
    check("collide_read", d, 32'h0);
    do_read(1'b1, d);
    check("collide_next", d, 32'h0002_0002);
    do_read(1'b1, d);
    check("collide_cleared", d, 32'h0000_0002);
    btn_raw[1] = 1'b0;
    tick(7);

`ifdef KEY_IRQ_EN
    // irq follows pending with one cycle of lag in both directions.
    btn_raw[4] = 1'b1;
    tick(5);
    check("irq_before_set", 32'(irq), 32'd0);
    tick();
    check("irq_on_set_edge", 32'(irq), 32'd0);
    tick();
    check("irq_raised", 32'(irq), 32'd1);
    do_read(1'b1, d);
    check("irq_read_word", d, 32'h0010_0010);
    check("irq_after_clear_edge", 32'(irq), 32'd1);
    tick();
    check("irq_fell", 32'(irq), 32'd0);
    btn_raw[4] = 1'b0;
    tick(7);
`endif

    // Reset in the middle of a btn[3] debounce leaves nothing behind.
    sw_raw = 16'h1234;
    tick(7);
    do_read(1'b0, d);
    check("sw_pre_abort", d, 32'h0000_1234);
    btn_raw[3] = 1'b1;
    tick(4);
    #2 reset = 1'b0;
    #1;
    check("async_reset_data", rd_data, 32'h0);
`ifdef KEY_IRQ_EN
    check("async_reset_irq", 32'(irq), 32'd0);
`endif
    btn_raw[3] = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(8);
    do_read(1'b1, d);
    check("abort_no_pending", d, 32'h0);
    do_read(1'b0, d);
    check("sw_after_abort", d, 32'h0000_1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
